// File: rtl/rvv_group_sequencer.sv
// rvv_group_sequencer: accepts vsetvl-style configuration and sequences one
// vector ALU op across a register group (LMUL registers), one register per
// cycle, producing registered writes with tail byte-enables.
// Optional feature: define RVV_SEQ_MASK_EN to add in_vm/v0 element masking.
module rvv_group_sequencer #(
  parameter int VLEN = 64,
  parameter int RA_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_avl,
  input  logic [2:0]            cfg_sew,
  input  logic [2:0]            cfg_lmul,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [RA_W-1:0]       in_vd,
  input  logic [RA_W-1:0]       in_vs1,
  input  logic [RA_W-1:0]       in_vs2,
  input  logic [31:0]           in_scalar,
`ifdef RVV_SEQ_MASK_EN
  input  logic                  in_vm,
  input  logic [VLEN-1:0]       v0,
`endif
  output logic [RA_W-1:0]       ra_a,
  output logic [RA_W-1:0]       ra_b,
  input  logic [VLEN-1:0]       rd_a,
  input  logic [VLEN-1:0]       rd_b,
  output logic                  we,
  output logic [RA_W-1:0]       wa,
  output logic [VLEN-1:0]       wd,
  output logic [VLEN/8-1:0]     wbe,
  output logic [$clog2(VLEN):0] vl,
  output logic [6:0]            vtype,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int VL_W = $clog2(VLEN) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      idx_reg;
  logic [2:0]      op_reg;
  logic [RA_W-1:0] vd_reg, vs1_reg, vs2_reg;
  logic [31:0]     scalar_reg;
`ifdef RVV_SEQ_MASK_EN
  logic            vm_reg;
`endif

  // Group geometry derived from the current vtype
  logic            vill;
  logic [3:0]      group_len;
  logic [2:0]      align_mask;
  logic            last_idx;
  logic            misaligned;
  logic            accept;
  logic            op_bad;
  logic            start_run;

  assign vill       = vtype[6];
  assign group_len  = 4'd1 << vtype[1:0];
  assign align_mask = 3'(group_len - 4'd1);
  assign last_idx   = (idx_reg == align_mask);
  assign misaligned = |((in_vd | in_vs1 | in_vs2) & RA_W'(align_mask));
  assign in_ready   = (state_reg == IDLE);
  assign accept     = in_ready && in_valid && !cfg_valid;
  assign op_bad     = vill || (in_op == 3'b111) || misaligned;
  assign start_run  = accept && !op_bad && (vl != '0);

  assign ra_a = vs2_reg + RA_W'(idx_reg);
  assign ra_b = vs1_reg + RA_W'(idx_reg);

  // Configuration decode: legality, VLMAX and clamped vl
  logic            cfg_legal;
  logic [15:0]     vlmax;
  logic [VL_W-1:0] cfg_vl;
  always_comb begin
    cfg_legal = !cfg_sew[2] && !cfg_lmul[2] &&
                ((16'd8 << cfg_sew[1:0]) <= 16'(VLEN));
    vlmax     = (16'(VLEN / 8) >> cfg_sew[1:0]) << cfg_lmul[1:0];
    cfg_vl    = '0;
    if (cfg_legal) begin
      if (16'(cfg_avl) < vlmax) cfg_vl = VL_W'(cfg_avl);
      else                      cfg_vl = VL_W'(vlmax);
    end
  end

  // Per-SEW datapaths; the active one is selected by vtype.sew
  logic [VLEN-1:0]   res_by_sew [4];
  logic [VLEN/8-1:0] be_by_sew  [4];

  for (genvar gs = 0; gs < 4; gs++) begin : g_sew
    localparam int SW = 8 << gs;
    if (SW <= VLEN) begin : g_ok
      localparam int NE   = VLEN / SW;
      localparam int SH_W = $clog2(SW);
      logic [SW-1:0]     sc;
      logic [VLEN-1:0]   res;
      logic [VLEN/8-1:0] be;

      // Scalar is sign-extended to 64 bits, then truncated to SEW
      assign sc = SW'({{32{scalar_reg[31]}}, scalar_reg});

      for (genvar ge = 0; ge < NE; ge++) begin : g_el
        logic [SW-1:0] ea, eb, er;
        logic [15:0]   gidx;
        logic          act;

        assign ea = rd_a[ge*SW +: SW];
        assign eb = rd_b[ge*SW +: SW];

        // Element ALU, all arithmetic wraps modulo 2^SEW
        always_comb begin
          er = '0;
          case (op_reg)
            3'b000:  er = ea + eb;
            3'b001:  er = ea - eb;
            3'b010:  er = ea & eb;
            3'b011:  er = ea | eb;
            3'b100:  er = ea ^ eb;
            3'b101:  er = ea + sc;
            3'b110:  er = ea << sc[SH_W-1:0];
            default: er = '0;
          endcase
        end

        assign gidx = 16'(idx_reg) * 16'(NE) + 16'(ge);
`ifdef RVV_SEQ_MASK_EN
        assign act = (gidx < 16'(vl)) &&
                     (vm_reg || v0[gidx[$clog2(VLEN)-1:0]]);
`else
        assign act = (gidx < 16'(vl));
`endif
        assign res[ge*SW +: SW]         = er;
        assign be[ge*(SW/8) +: (SW/8)]  = {(SW/8){act}};
      end

      assign res_by_sew[gs] = res;
      assign be_by_sew[gs]  = be;
    end else begin : g_none
      assign res_by_sew[gs] = '0;
      assign be_by_sew[gs]  = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // FSM next state: IDLE waits for a runnable op, RUN walks the group
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_run) state_next = RUN;
      RUN:     if (last_idx)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // vl/vtype only change on a cfg seen while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vl    <= '0;
      vtype <= 7'b1000000;
    end else if (in_ready && cfg_valid) begin
      vl    <= cfg_vl;
      vtype <= cfg_legal ? {1'b0, cfg_sew, cfg_lmul} : 7'b1000000;
    end
  end

  // Operand capture at acceptance and group index stepping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg    <= '0;
      op_reg     <= '0;
      vd_reg     <= '0;
      vs1_reg    <= '0;
      vs2_reg    <= '0;
      scalar_reg <= '0;
`ifdef RVV_SEQ_MASK_EN
      vm_reg     <= 1'b1;
`endif
    end else if (accept) begin
      idx_reg    <= '0;
      op_reg     <= in_op;
      vd_reg     <= in_vd;
      vs1_reg    <= in_vs1;
      vs2_reg    <= in_vs2;
      scalar_reg <= in_scalar;
`ifdef RVV_SEQ_MASK_EN
      vm_reg     <= in_vm;
`endif
    end else if (state_reg == RUN) begin
      idx_reg    <= idx_reg + 3'd1;
    end
  end

  // Registered write port and status pulses, one cycle behind the read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we   <= 1'b0;
      wa   <= '0;
      wd   <= '0;
      wbe  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      busy <= 1'b0;
    end else begin
      we   <= (state_reg == RUN);
      done <= ((state_reg == RUN) && last_idx) ||
              (accept && !op_bad && (vl == '0));
      err  <= accept && op_bad;
      busy <= (state_next == RUN) || (state_reg == RUN);
      if (state_reg == RUN) begin
        wa  <= vd_reg + RA_W'(idx_reg);
        wd  <= res_by_sew[vtype[4:3]];
        wbe <= be_by_sew[vtype[4:3]];
      end
    end
  end

endmodule

// File: tb/tb_rvv_group_sequencer.sv
// Self-checking bench for rvv_group_sequencer (VLEN=64, default build).
// A behavioural model computes vl/vtype and the expected write stream from
// element-level arithmetic; random configs and ops plus directed cases.
module tb_rvv_group_sequencer;
  localparam int VLEN = 64;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic [7:0]      cfg_avl = '0;
  logic [2:0]      cfg_sew = '0;
  logic [2:0]      cfg_lmul = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = '0;
  logic [RA_W-1:0] in_vd = '0, in_vs1 = '0, in_vs2 = '0;
  logic [31:0]     in_scalar = '0;
  logic [RA_W-1:0] ra_a, ra_b;
  logic [VLEN-1:0] rd_a, rd_b;
  logic            we;
  logic [RA_W-1:0] wa;
  logic [VLEN-1:0] wd;
  logic [7:0]      wbe;
  logic [6:0]      vl;
  logic [6:0]      vtype;
  logic            busy, done, err;

  logic [63:0] rf [32];
  assign rd_a = rf[ra_a];
  assign rd_b = rf[ra_b];

  rvv_group_sequencer #(.VLEN(VLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_avl(cfg_avl), .cfg_sew(cfg_sew), .cfg_lmul(cfg_lmul),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_scalar(in_scalar),
    .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b),
    .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .vl(vl), .vtype(vtype), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of architectural configuration state
  int       m_vl   = 0;
  bit       m_vill = 1'b1;
  int       m_sew  = 0;
  int       m_lmul = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cfg(input int avl, input int sew, input int lmul);
    int sb, vmax;
    sb = (sew < 4) ? (8 << sew) : 1024;
    if (sew > 3 || lmul > 3 || sb > VLEN) begin
      m_vill = 1'b1;
      m_vl   = 0;
    end else begin
      m_vill = 1'b0;
      m_sew  = sew;
      m_lmul = lmul;
      vmax   = (VLEN / sb) * (1 << lmul);
      m_vl   = (avl < vmax) ? avl : vmax;
    end
  endtask

  task automatic check_cfg();
    check_value("vl", vl, m_vl);
    check_value("vill", vtype[6], m_vill);
    if (!m_vill) check_value("vtype", vtype, {1'b0, 3'(m_sew), 3'(m_lmul)});
  endtask

  task automatic do_cfg(input int avl, input int sew, input int lmul);
    cfg_valid = 1'b1;
    cfg_avl   = 8'(avl);
    cfg_sew   = 3'(sew);
    cfg_lmul  = 3'(lmul);
    tick();
    cfg_valid = 1'b0;
    model_cfg(avl, sew, lmul);
    check_cfg();
    $display("cfg avl=%0d sew=%0d lmul=%0d -> vl=%0d vtype=%07b", avl, sew, lmul, vl, vtype);
  endtask

  task automatic op_drive(input logic [2:0] op, input int vd, input int vs1, input int vs2,
                          input logic [31:0] sc);
    in_op     = op;
    in_vd     = RA_W'(vd);
    in_vs1    = RA_W'(vs1);
    in_vs2    = RA_W'(vs2);
    in_scalar = sc;
    in_valid  = 1'b1;
  endtask

  // Accepts the driven op and watches the following cycles against the model
  task automatic finish_op(input logic [2:0] op, input int vd, input int vs1, input int vs2,
                           input logic [31:0] sc);
    int L, sb, ne, kind, nw, nbusy, ndone, nerr, err_at, done_at, first_we, last_we;
    logic [63:0] exp_wd [8];
    logic [7:0]  exp_be [8];
    logic [63:0] msk, scx, a, b, r, bm;
    L = m_vill ? 1 : (1 << m_lmul);
    if (m_vill || op == 3'b111 || (vd % L) != 0 || (vs1 % L) != 0 || (vs2 % L) != 0) kind = 0;
    else if (m_vl == 0) kind = 1;
    else kind = 2;
    for (int i = 0; i < 8; i++) begin
      exp_wd[i] = '0;
      exp_be[i] = '0;
    end
    if (kind == 2) begin
      sb  = 8 << m_sew;
      ne  = VLEN / sb;
      msk = (sb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sb) - 64'd1);
      scx = {{32{sc[31]}}, sc} & msk;
      for (int i = 0; i < L; i++) begin
        for (int j = 0; j < ne; j++) begin
          a = (rf[vs2 + i] >> (j * sb)) & msk;
          b = (rf[vs1 + i] >> (j * sb)) & msk;
          case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a + scx;
            3'd6:    r = a << (sc % 32'(sb));
            default: r = '0;
          endcase
          r = r & msk;
          exp_wd[i] = exp_wd[i] | (r << (j * sb));
          if (i * ne + j < m_vl)
            for (int k = 0; k < sb / 8; k++) exp_be[i][j * (sb / 8) + k] = 1'b1;
        end
      end
    end
    check_value("in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    nw = 0; nbusy = 0; ndone = 0; nerr = 0;
    err_at = 0; done_at = 0; first_we = 0; last_we = 0;
    for (int c = 1; c <= 12; c++) begin
      if (busy) nbusy++;
      if (err) begin nerr++; err_at = c; end
      if (done) begin ndone++; done_at = c; end
      if (we) begin
        if (first_we == 0) first_we = c;
        last_we = c;
        if (kind == 2 && nw < L) begin
          bm = '0;
          for (int k = 0; k < 8; k++) if (exp_be[nw][k]) bm[k*8 +: 8] = 8'hFF;
          check_value("wa", wa, 64'(vd + nw));
          check_value("wbe", wbe, exp_be[nw]);
          check_value("wd", wd & bm, exp_wd[nw] & bm);
          check_value("done_with_last_write", done, (nw == L - 1));
        end
        nw++;
      end
      tick();
    end
    case (kind)
      0: begin
        check_value("err_count", nerr, 1);
        check_value("err_cycle", err_at, 1);
        check_value("writes_on_err", nw, 0);
        check_value("done_on_err", ndone, 0);
      end
      1: begin
        check_value("done_count", ndone, 1);
        check_value("done_cycle", done_at, 1);
        check_value("writes_vl0", nw, 0);
        check_value("err_vl0", nerr, 0);
      end
      default: begin
        check_value("write_count", nw, L);
        check_value("first_write_cycle", first_we, 2);
        check_value("last_write_cycle", last_we, L + 1);
        check_value("done_count", ndone, 1);
        check_value("done_cycle", done_at, L + 1);
        check_value("busy_cycles", nbusy, L + 1);
        check_value("err_on_run", nerr, 0);
      end
    endcase
    $display("op=%0d vd=%0d vs1=%0d vs2=%0d sc=%08h kind=%0d writes=%0d", op, vd, vs1, vs2, sc, kind, nw);
  endtask

  task automatic run_op(input logic [2:0] op, input int vd, input int vs1, input int vs2,
                        input logic [31:0] sc);
    op_drive(op, vd, vs1, vs2, sc);
    finish_op(op, vd, vs1, vs2, sc);
  endtask

  initial begin
    int L, vd, vs1, vs2, sew, lmul, nwe;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #2;
    check_value("rst_we", we, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_err", err, 0);
    check_value("rst_wbe", wbe, 0);
    check_value("rst_wa", wa, 0);
    check_value("rst_wd", wd, 0);
    check_value("rst_vl", vl, 0);
    check_value("rst_vtype", vtype, 7'b1000000);
    check_value("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b1;
    tick();

    // Basic vadd, vl=5 tail
    rf[3] = 64'h0101_0101_0101_0101;
    rf[4] = 64'h0101_0101_0101_0101;
    do_cfg(5, 0, 0);
    run_op(3'd0, 2, 3, 4, 32'h0);

    // Four-register group vsub
    do_cfg(200, 1, 2);
    run_op(3'd1, 8, 12, 16, 32'h0);

    // Reserved SEW
    do_cfg(10, 4, 0);
    run_op(3'd0, 0, 0, 0, 32'h0);

    // Misaligned group and vl=0
    do_cfg(10, 0, 1);
    run_op(3'd0, 3, 4, 6, 32'h0);
    do_cfg(0, 0, 0);
    run_op(3'd2, 1, 2, 3, 32'h0);

    // cfg and op in the same cycle: cfg wins, op accepted next cycle
    rf[6] = 64'h0000_0001_0000_0001;
    op_drive(3'd5, 5, 7, 6, 32'hFFFF_FFFF);
    cfg_valid = 1'b1; cfg_avl = 8'd2; cfg_sew = 3'd2; cfg_lmul = 3'd0;
    tick();
    cfg_valid = 1'b0;
    model_cfg(2, 2, 0);
    check_cfg();
    check_value("coincide_busy", busy, 0);
    check_value("coincide_err", err, 0);
    check_value("coincide_done", done, 0);
    finish_op(3'd5, 5, 7, 6, 32'hFFFF_FFFF);

    // Reset during RUN after the first write
    do_cfg(200, 1, 2);
    op_drive(3'd1, 8, 12, 16, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_value("midrun_first_we", we, 1);
    #2 rst = 1'b0;
    #1;
    check_value("midrun_rst_we", we, 0);
    check_value("midrun_rst_vtype", vtype, 7'b1000000);
    check_value("midrun_rst_vl", vl, 0);
    check_value("midrun_rst_busy", busy, 0);
    tick();
    rst = 1'b1;
    nwe = 0;
    for (int c = 0; c < 8; c++) begin
      if (we) nwe++;
      tick();
    end
    check_value("midrun_no_more_writes", nwe, 0);
    m_vill = 1'b1;
    m_vl   = 0;
    $display("reset during run, writes after reset=%0d", nwe);

    // Randomized configs and ops
    for (int it = 0; it < 50; it++) begin
      sew  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      lmul = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      do_cfg(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255), sew, lmul);
      for (int k = 0; k < 3; k++) begin
        L = m_vill ? 1 : (1 << m_lmul);
        vd  = $urandom_range(0, 32 / L - 1) * L;
        vs1 = $urandom_range(0, 32 / L - 1) * L;
        vs2 = $urandom_range(0, 32 / L - 1) * L;
        if ($urandom_range(0, 5) == 0) vd = $urandom_range(0, 32 - L);
        run_op(3'($urandom_range(0, 7)), vd, vs1, vs2, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvv_group_sequencer.md
RVV_GROUP_SEQUENCER -- requirements
Module: rvv_group_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 64, vector register width in bits (power of two, 64..512).
REQ-002 SHALL have parameter RA_W, default 5, register address width.
REQ-003 SHALL have ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
cfg_valid  in  1  vsetvl request.
cfg_avl  in  8  application vector length.
cfg_sew  in  3  encoded SEW: 000=8, 001=16, 010=32, 011=64.
cfg_lmul  in  3  encoded LMUL: 000=1, 001=2, 010=4, 011=8.
in_valid  in  1  vector op request.
in_ready  out  1  op/cfg acceptance.
in_op  in  3  ALU op.
in_vd, in_vs1, in_vs2  in  RA_W  group base registers.
in_scalar  in  32  scalar operand.
ra_a, ra_b  out  RA_W  regfile read addresses (vs2+idx, vs1+idx).
rd_a, rd_b  in  VLEN  combinational read data.
we  out  1  regfile write enable.
wa  out  RA_W  write address.
wd  out  VLEN  write data.
wbe  out  VLEN/8  byte write enables.
vl  out  $clog2(VLEN)+1  current vl.
vtype  out  7  {vill, sew[2:0], lmul[2:0]}.
busy, done, err  out  1  status; done/err are one-cycle pulses.

Function
REQ-004 SHALL operate as FSM IDLE/RUN; in_ready=1 only in IDLE.
REQ-005 SHALL accept cfg on cfg_valid in IDLE: VLMAX=(VLEN/SEW)*LMUL; vl<=min(cfg_avl,VLMAX); vtype<={0,sew,lmul}; takes effect next cycle.
REQ-006 SHALL, on reserved or oversize SEW (SEW>VLEN) or reserved LMUL, set vill=1 and vl=0.
REQ-007 SHALL give cfg priority when cfg_valid and in_valid coincide; op not accepted that cycle.
REQ-008 SHALL accept op on in_valid & in_ready & !cfg_valid; latch operands; enter RUN with idx=0.
REQ-009 SHALL pulse err (one cycle after acceptance), write nothing, stay IDLE, when vill=1, op=111, or vd/vs1/vs2 not a multiple of LMUL.
REQ-010 SHALL, when vl=0 and op legal, pulse done one cycle after acceptance with no writes.
REQ-011 SHALL in RUN drive ra_a=vs2+idx, ra_b=vs1+idx for idx=0..LMUL-1, one register per cycle; exit to IDLE after idx=LMUL-1.
REQ-012 SHALL register results: we/wa=vd+idx/wd/wbe valid exactly one cycle after the read cycle; done pulses with the last write.
REQ-013 SHALL compute per SEW element, modulo 2^SEW: 000 add, 001 sub (vs2-vs1), 010 and, 011 or, 100 xor, 101 vs2+scalar, 110 vs2<<(scalar mod SEW); scalar sign-extended/truncated to SEW.
REQ-014 SHALL clear wbe bytes of elements with global index idx*(VLEN/SEW)+j >= vl (tail undisturbed); we still asserted for every group register.
REQ-015 SHALL hold busy=1 from acceptance to the cycle of the final write inclusive.
REQ-016 SHALL keep vl/vtype unchanged during RUN; cfg is ignored while in_ready=0.

Reset
REQ-017 SHALL on rst=0 asynchronously enter IDLE, clearing idx, we, wbe, wa, wd, done, err, busy to 0, vl=0, vtype=7'b1000000 (vill set).
REQ-018 SHALL abandon an in-flight op on mid-RUN reset with no further writes.

Configuration
REQ-019 SHALL, with RVV_SEQ_MASK_EN defined, add ports in_vm (1) and v0 (VLEN); when in_vm=0, element i with v0[i]=0 has its wbe bytes cleared; in_vm latched at acceptance, v0 sampled each RUN cycle.
REQ-020 SHALL, without RVV_SEQ_MASK_EN, omit those ports; all body elements active.

Verification
REQ-021 VLEN=64: cfg avl=5 sew=8 lmul=1 -> vl=5, vtype=0000000; vadd vd=2 vs1=3 vs2=4, rd_a=rd_b=8'h01 per byte -> one write wa=2, wd bytes 8'h02, wbe=8'h1F, done with it.
REQ-022 cfg avl=200 sew=16 lmul=4 -> vl=16; vsub vd=8 -> writes wa=8,9,10,11 on 4 consecutive cycles, all wbe=FF, busy 5 cycles.
REQ-023 cfg sew=3'b100 -> vill=1, vl=0; any op -> err pulse, we never asserts.
REQ-024 lmul=2, vd=3 -> err, no writes; vl=0 legal op -> done only.
REQ-025 vadd.vx sew=32 scalar=32'hFFFFFFFF, rd_a elements 1 -> wd elements 0 (wrap); cfg and op same cycle -> cfg applied, op accepted next cycle.
REQ-026 rst low in RUN after first write -> we=0 immediately, vtype=1000000, no further writes.
